ccd_icg_gen: RTL and testbench

CCD_ICG_GEN -- requirements
Module: ccd_icg_gen

---
 rtl/ccd_icg_gen_pkg.sv | 18 +
 rtl/ccd_icg_gen_if.sv | 17 +
 rtl/ccd_icg_gen_frame_counter.sv | 27 ++
 rtl/ccd_icg_gen.sv | 69 ++++++
 tb/tb_ccd_icg_gen.sv | 142 ++++++++++++++
 5 files changed

// File: rtl/ccd_icg_gen_pkg.sv
// Shared CCD timing package: default frame/ICG/SH constants and the
// counter-width helper used by ccd_icg_gen and ccd_frame_counter.
package ccd_timing_pkg;

    // Defaults assume a 50 MHz Master_clk.
    localparam int unsigned DEF_FRAME_CYCLES   = 500000; // 10 ms frame
    localparam int unsigned DEF_ICG_LOW_CYCLES = 250;    // 5 us ICG low pulse
    localparam int unsigned DEF_SH_DELAY       = 25;     // ICG fall -> SH rise
    localparam int unsigned DEF_SH_WIDTH       = 50;     // SH high width

    // Width of a counter spanning 0..n-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        int unsigned w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/ccd_icg_gen_if.sv
// CCD gate-drive bundle (ICG, and SH when CCD_ICG_SH_EN is defined).
// The generator drives it through the master modport; the sensor side,
// or a bench, observes it through the slave modport.
interface ccd_icg_gen_if;

    logic CCD_ICG;
`ifdef CCD_ICG_SH_EN
    logic CCD_SH;

    modport master (output CCD_ICG, output CCD_SH);
    modport slave  (input  CCD_ICG, input  CCD_SH);
`else
    modport master (output CCD_ICG);
    modport slave  (input  CCD_ICG);
`endif

endinterface

// File: rtl/ccd_icg_gen_frame_counter.sv
// ccd_frame_counter: free-running wrap-around counter, 0..MODULUS-1,
// synchronous active-high reset to zero.
module ccd_frame_counter
    import ccd_timing_pkg::*;
#(
    parameter  int unsigned MODULUS = DEF_FRAME_CYCLES,
    localparam int unsigned W       = cnt_width(MODULUS)
) (
    input  logic         clk,
    input  logic         rst,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] LAST = W'(MODULUS - 1);

    // Advance every edge, wrapping from LAST back to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ccd_icg_gen.sv
// ccd_icg_gen: CCD integration-clear-gate (ICG) generator.
// ICG idles high and pulses low for ICG_LOW_CYCLES at the start of every
// FRAME_CYCLES-long frame. Define CCD_ICG_SH_EN to add the CCD_SH port and
// its shift-gate pulse, nested inside the ICG low pulse.
// Outputs come straight from flops; reset is synchronous, active-high.
module ccd_icg_gen
    import ccd_timing_pkg::*;
#(
    parameter int unsigned FRAME_CYCLES   = DEF_FRAME_CYCLES,
    parameter int unsigned ICG_LOW_CYCLES = DEF_ICG_LOW_CYCLES,
    parameter int unsigned SH_DELAY       = DEF_SH_DELAY,
    parameter int unsigned SH_WIDTH       = DEF_SH_WIDTH
) (
    input  logic Master_clk,
    input  logic rst,
`ifdef CCD_ICG_SH_EN
    output logic CCD_SH,
`endif
    output logic CCD_ICG
);

    localparam int unsigned CNT_W = cnt_width(FRAME_CYCLES);

    // Parameter sanity: the ICG pulse must be non-empty and shorter than a frame.
    if (!(ICG_LOW_CYCLES >= 1 && ICG_LOW_CYCLES < FRAME_CYCLES)) begin : g_bad_icg
        $error("ccd_icg_gen: need 1 <= ICG_LOW_CYCLES < FRAME_CYCLES");
    end

    logic [CNT_W-1:0] cnt;

    ccd_frame_counter #(
        .MODULUS (FRAME_CYCLES)
    ) u_frame_counter (
        .clk (Master_clk),
        .rst (rst),
        .cnt (cnt)
    );

    localparam logic [CNT_W-1:0] ICG_THR = CNT_W'(ICG_LOW_CYCLES);

    // ICG low while the pre-update count is inside the first ICG_LOW_CYCLES.
    always_ff @(posedge Master_clk) begin
        if (rst) begin
            CCD_ICG <= 1'b1;
        end else begin
            CCD_ICG <= (cnt >= ICG_THR);
        end
    end

`ifdef CCD_ICG_SH_EN
    // SH must sit strictly inside the ICG low pulse.
    if (!(SH_DELAY >= 1 && SH_WIDTH >= 1 && SH_DELAY + SH_WIDTH < ICG_LOW_CYCLES)) begin : g_bad_sh
        $error("ccd_icg_gen: need SH_DELAY>=1, SH_WIDTH>=1, SH_DELAY+SH_WIDTH < ICG_LOW_CYCLES");
    end

    localparam logic [CNT_W-1:0] SH_START = CNT_W'(SH_DELAY);
    localparam logic [CNT_W-1:0] SH_END   = CNT_W'(SH_DELAY + SH_WIDTH);

    // SH high for counts SH_DELAY..SH_DELAY+SH_WIDTH-1, same pre-update count.
    always_ff @(posedge Master_clk) begin
        if (rst) begin
            CCD_SH <= 1'b0;
        end else begin
            CCD_SH <= (cnt >= SH_START) && (cnt < SH_END);
        end
    end
`endif

endmodule

// File: tb/tb_ccd_icg_gen.sv
// Bench for ccd_icg_gen with FRAME=20, ICG_LOW=6, SH_DELAY=1, SH_WIDTH=2.
// Reference model: edges elapsed since reset release, mapped to a phase
// within the frame; outputs follow from the phase by the timing rules.
module tb_ccd_icg_gen;

    localparam int unsigned F   = 20;
    localparam int unsigned LOW = 6;
    localparam int unsigned SHD = 1;
    localparam int unsigned SHW = 2;

    logic Master_clk = 1'b0;
    logic rst        = 1'b1;

    always #5 Master_clk = ~Master_clk;

    ccd_icg_gen_if ccd ();

    ccd_icg_gen #(
        .FRAME_CYCLES   (F),
        .ICG_LOW_CYCLES (LOW),
        .SH_DELAY       (SHD),
        .SH_WIDTH       (SHW)
    ) dut (
        .Master_clk (Master_clk),
        .rst        (rst),
`ifdef CCD_ICG_SH_EN
        .CCD_SH     (ccd.CCD_SH),
`endif
        .CCD_ICG    (ccd.CCD_ICG)
    );

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned k     = 0;   // edges since release
    logic exp_icg;
    logic exp_sh;

    // Advance one edge, update the model from the rst level seen at it, check.
    task automatic tick(input string tag);
        int unsigned phase;
        @(posedge Master_clk);
        #1;
        if (rst) begin
            k       = 0;
            exp_icg = 1'b1;
            exp_sh  = 1'b0;
        end else begin
            k       = k + 1;
            phase   = (k - 1) % F;
            exp_icg = (phase >= LOW);
            exp_sh  = (phase >= SHD) && (phase < SHD + SHW);
        end
        total++;
        assert (ccd.CCD_ICG === exp_icg) else begin
            bad++;
            $error("FAIL %s icg k=%0d observed=%b expected=%b", tag, k, ccd.CCD_ICG, exp_icg);
        end
`ifdef CCD_ICG_SH_EN
        total++;
        assert (ccd.CCD_SH === exp_sh) else begin
            bad++;
            $error("FAIL %s sh k=%0d observed=%b expected=%b", tag, k, ccd.CCD_SH, exp_sh);
        end
`endif
    endtask

    initial begin
        logic        prev;
        logic        cur;
        int unsigned run;
        int unsigned last_fall;
        bit          have_fall;
        int unsigned hold;

        // Reset state.
        rst = 1'b1;
        for (int i = 0; i < 3; i++) tick("reset");

        // Release: low edges 1..6, high 7..20, low again at 21.
        rst = 1'b0;
        for (int i = 0; i < 21; i++) tick("release");

        // Five frames: explicit pulse width and fall spacing.
        rst = 1'b1;
        tick("reset2");
        rst       = 1'b0;
        prev      = 1'b1;
        run       = 0;
        last_fall = 0;
        have_fall = 1'b0;
        for (int e = 1; e <= 5 * F; e++) begin
            tick("frames");
            cur = ccd.CCD_ICG;
            if (prev === 1'b1 && cur === 1'b0) begin
                if (have_fall) begin
                    total++;
                    assert (e - last_fall == F) else begin
                        bad++;
                        $error("FAIL period observed=%0d expected=%0d", e - last_fall, F);
                    end
                end
                have_fall = 1'b1;
                last_fall = e;
                run       = 0;
            end
            if (cur === 1'b0) run++;
            if (prev === 1'b0 && cur === 1'b1) begin
                total++;
                assert (run == LOW) else begin
                    bad++;
                    $error("FAIL width observed=%0d expected=%0d", run, LOW);
                end
            end
            prev = cur;
        end

        // Mid-pulse reset: one reset edge after 3 low edges, then a full pulse.
        rst = 1'b1;
        tick("midpre");
        rst = 1'b0;
        for (int i = 0; i < 3; i++) tick("midlow");
        rst = 1'b1;
        tick("midrst");
        rst = 1'b0;
        for (int i = 0; i < F + 2; i++) tick("midafter");

        // Random reset bursts on top of free-running frames.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                hold = $urandom_range(1, 3);
                rst  = 1'b1;
                for (int j = 0; j < int'(hold); j++) tick("rndrst");
                rst = 1'b0;
            end
            tick("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
